pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipeline_controller_load_use_detect.sv | 24 ++
 rtl/pipeline_controller.sv | 143 ++++++++++++++
 tb/tb_pipeline_controller.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, HALT opcode,
// drain length default and small state-classification helpers.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int         DRAIN_CYCLES_DEFAULT = 3;
    localparam logic [5:0] HALT_OPCODE          = 6'b111111;

    // States in which instructions are fetched and advanced through the front end.
    function automatic logic is_advancing(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

    // States that consume a pipeline cycle and therefore bump the cycle counter.
    function automatic logic counts_cycle(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID is about to read.
module load_use_detect #(
    parameter int NB_ADDR = 5
) (
    input  logic               i_ex_memRead,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic               i_id_uses_rt,
    output logic               o_hazard
);

    logic dest_valid;
    logic rs_match;
    logic rt_match;

    // Register zero is hardwired, so a load targeting it can never create a dependency.
    assign dest_valid = i_ex_memRead && (i_ex_rt != '0);
    assign rs_match   = (i_ex_rt == i_id_rs);
    assign rt_match   = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_hazard   = dest_valid && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_controller.sv
// Debug-driven pipeline controller: run/step/halt sequencing, load-use stall
// insertion, jump flush and a saturating executed-cycle counter.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_ADDR      = 5,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int NB_CNT       = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_debug_run,
    input  logic               i_debug_step,
    input  logic               i_id_halt,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic               i_id_uses_rt,
    input  logic               i_ex_memRead,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    input  logic               i_id_jump,
    output logic               o_pc_en,
    output logic               o_ifid_en,
    output logic               o_ifid_flush,
    output logic               o_id_stall,
    output logic               o_pipe_en,
    output logic [2:0]         o_state,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_cycle_cnt
);

    localparam int                NB_DRAIN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    state_t              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic [NB_CNT-1:0]   cnt_q,   cnt_d;
    logic                halted_q;
    logic                hazard;

    load_use_detect #(
        .NB_ADDR (NB_ADDR)
    ) u_load_use_detect (
        .i_ex_memRead (i_ex_memRead),
        .i_ex_rt      (i_ex_rt),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .o_hazard     (hazard)
    );

    // Enables react to the hazard in the same cycle so the dependent
    // instruction is held in ID while a bubble enters ID/EX.
    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_id_stall   = 1'b0;
        o_pipe_en    = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP: begin
                o_pipe_en = 1'b1;
                if (hazard) begin
                    o_id_stall = 1'b1;
                end else begin
                    o_pc_en      = 1'b1;
                    o_ifid_en    = 1'b1;
                    o_ifid_flush = i_id_jump;
                end
            end
            ST_DRAIN: begin
                o_id_stall = 1'b1;
                o_pipe_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_debug_run) begin
                    state_d = ST_RUN;
                end else if (i_debug_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!hazard && i_id_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (!i_debug_run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                // A stalled step has not advanced anything yet, so it stays pending.
                if (!hazard) begin
                    if (i_id_halt) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_IDLE;
        endcase

        if (counts_cycle(state_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign o_state     = state_q;
    assign o_halted    = halted_q;
    assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scenario bench for pipeline_controller: each task queues per-cycle expected
// outputs alongside its stimulus and compares them against the DUT each cycle.
module tb_pipeline_controller;

    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 4;
    localparam int W       = 9 + NB_CNT;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    // {pc_en, ifid_en, flush, stall, pipe_en}
    localparam logic [4:0] F_OFF   = 5'b00000;
    localparam logic [4:0] F_ADV   = 5'b11001;
    localparam logic [4:0] F_JMP   = 5'b11101;
    localparam logic [4:0] F_STALL = 5'b00011;

    typedef struct packed {
        logic               rst;
        logic               run;
        logic               step;
        logic               halt;
        logic               mr;
        logic [NB_ADDR-1:0] ex_rt;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic               urt;
        logic               jump;
    } stim_t;

    typedef struct packed {
        logic [4:0]        flags;
        logic [2:0]        state;
        logic              halted;
        logic [NB_CNT-1:0] cnt;
    } exp_t;

    logic               clk;
    logic               i_rst;
    logic               i_debug_run;
    logic               i_debug_step;
    logic               i_id_halt;
    logic [NB_ADDR-1:0] i_id_rs;
    logic [NB_ADDR-1:0] i_id_rt;
    logic               i_id_uses_rt;
    logic               i_ex_memRead;
    logic [NB_ADDR-1:0] i_ex_rt;
    logic               i_id_jump;
    logic               o_pc_en;
    logic               o_ifid_en;
    logic               o_ifid_flush;
    logic               o_id_stall;
    logic               o_pipe_en;
    logic [2:0]         o_state;
    logic               o_halted;
    logic [NB_CNT-1:0]  o_cycle_cnt;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    pipeline_controller #(
        .NB_ADDR      (NB_ADDR),
        .DRAIN_CYCLES (3),
        .NB_CNT       (NB_CNT)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_debug_run  (i_debug_run),
        .i_debug_step (i_debug_step),
        .i_id_halt    (i_id_halt),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .i_ex_memRead (i_ex_memRead),
        .i_ex_rt      (i_ex_rt),
        .i_id_jump    (i_id_jump),
        .o_pc_en      (o_pc_en),
        .o_ifid_en    (o_ifid_en),
        .o_ifid_flush (o_ifid_flush),
        .o_id_stall   (o_id_stall),
        .o_pipe_en    (o_pipe_en),
        .o_state      (o_state),
        .o_halted     (o_halted),
        .o_cycle_cnt  (o_cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t sv(input logic rst, input logic run, input logic step,
                                 input logic halt, input logic mr, input int ex_rt,
                                 input int rs, input int rt, input logic urt, input logic jump);
        stim_t s;
        s.rst   = rst;
        s.run   = run;
        s.step  = step;
        s.halt  = halt;
        s.mr    = mr;
        s.ex_rt = NB_ADDR'(ex_rt);
        s.rs    = NB_ADDR'(rs);
        s.rt    = NB_ADDR'(rt);
        s.urt   = urt;
        s.jump  = jump;
        return s;
    endfunction

    function automatic exp_t ev(input logic [4:0] flags, input logic [2:0] st,
                                input logic halted, input int cnt);
        exp_t e;
        e.flags  = flags;
        e.state  = st;
        e.halted = halted;
        e.cnt    = NB_CNT'(cnt);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        i_rst        = s.rst;
        i_debug_run  = s.run;
        i_debug_step = s.step;
        i_id_halt    = s.halt;
        i_ex_memRead = s.mr;
        i_ex_rt      = s.ex_rt;
        i_id_rs      = s.rs;
        i_id_rt      = s.rt;
        i_id_uses_rt = s.urt;
        i_id_jump    = s.jump;
    endtask

    task automatic do_reset();
        apply(sv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        @(posedge clk);
        #1;
        s.push_back(sv(1, 1, 1, 1, 1, 3, 3, 0, 0, 1)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        s.push_back(sv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        s.push_back(sv(0, 0, 0, 1, 1, 3, 3, 0, 0, 1)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_reset row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_step();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV, S_STEP, 0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 1));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 1));
        s.push_back(sv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 1));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV, S_RUN,  0, 1));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 2));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_step row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hazard();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE, 0, 0));
        s.push_back(sv(0, 1, 0, 0, 1, 8, 8, 0, 0, 0)); e.push_back(ev(F_STALL, S_RUN,  0, 0));
        s.push_back(sv(0, 1, 0, 0, 1, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 1));
        s.push_back(sv(0, 1, 0, 0, 1, 5, 1, 5, 1, 0)); e.push_back(ev(F_STALL, S_RUN,  0, 2));
        s.push_back(sv(0, 1, 0, 0, 1, 5, 1, 5, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 3));
        s.push_back(sv(0, 1, 0, 0, 0, 8, 8, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 4));
        s.push_back(sv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 5));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 6));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE, 0, 7));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_hazard row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE, 0, 0));
        s.push_back(sv(0, 1, 0, 0, 1, 8, 8, 0, 0, 1)); e.push_back(ev(F_STALL, S_RUN,  0, 0));
        s.push_back(sv(0, 1, 0, 0, 0, 8, 8, 0, 0, 1)); e.push_back(ev(F_JMP,   S_RUN,  0, 1));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 2));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,  0, 3));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(ev(F_OFF,   S_IDLE, 0, 4));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_jump row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,   0, 0));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,    0, 0));
        s.push_back(sv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,    0, 1));
        s.push_back(sv(0, 0, 1, 1, 1, 4, 4, 0, 0, 1)); e.push_back(ev(F_STALL, S_DRAIN,  0, 2));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN,  0, 3));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN,  0, 4));
        s.push_back(sv(0, 1, 1, 1, 0, 0, 0, 0, 0, 1)); e.push_back(ev(F_OFF,   S_HALTED, 1, 5));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_HALTED, 1, 5));
        s.push_back(sv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_HALTED, 1, 5));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,   0, 0));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,   0, 0));
        s.push_back(sv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,    0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN,  0, 1));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_halt row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_step_hazard();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 0));
        s.push_back(sv(0, 0, 0, 0, 1, 8, 8, 0, 0, 0)); e.push_back(ev(F_STALL, S_STEP,  0, 0));
        s.push_back(sv(0, 0, 0, 1, 1, 8, 8, 0, 0, 0)); e.push_back(ev(F_STALL, S_STEP,  0, 1));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_STEP,  0, 2));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 3));
        s.push_back(sv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 3));
        s.push_back(sv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_STEP,  0, 3));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN, 0, 4));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_step_hazard row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_drain_reset();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        do_reset();
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 0));
        s.push_back(sv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV,   S_RUN,   0, 0));
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN, 0, 1));
        s.push_back(sv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_STALL, S_DRAIN, 0, 2));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 0));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF,   S_IDLE,  0, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_drain_reset row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Random operand patterns in RUN; long enough to push the narrow counter into saturation.
    task automatic test_random_run();
        stim_t s[$];
        exp_t  e[$];
        logic [W-1:0] got, want;
        int cnt;
        logic mr, urt, jmp, haz;
        int ex_rt, rs, rt;
        do_reset();
        cnt = 0;
        s.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 0));
        for (int k = 0; k < 24; k++) begin
            mr    = 1'($urandom_range(0, 1));
            urt   = 1'($urandom_range(0, 1));
            jmp   = 1'($urandom_range(0, 1));
            ex_rt = $urandom_range(0, 3);
            rs    = $urandom_range(0, 3);
            rt    = $urandom_range(0, 3);
            haz   = mr && (ex_rt != 0) && ((ex_rt == rs) || (urt && (ex_rt == rt)));
            s.push_back(sv(0, 1, 0, 0, mr, ex_rt, rs, rt, urt, jmp));
            e.push_back(ev(haz ? F_STALL : (jmp ? F_JMP : F_ADV), S_RUN, 0, cnt));
            cnt = (cnt == 15) ? 15 : cnt + 1;
        end
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_ADV, S_RUN,  0, cnt));
        s.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ev(F_OFF, S_IDLE, 0, 15));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall, o_pipe_en, o_state, o_halted, o_cycle_cnt};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL test_random_run row %0d: got %b, expected %b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        apply(sv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_step();
        test_hazard();
        test_jump();
        test_halt();
        test_step_hazard();
        test_drain_reset();
        test_random_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
